decode_stage_param: RTL

- Parametrised Y86-64 decode/writeback stage.
- Holds the architectural register file with two synchronous write ports, driven by the W_dst_e and W_dst_m writeback.
- Decodes source and destination register IDs per icode. Resolves operands with the full forwarding priority chain.
- Registers the result into the D->E pipeline register. That register supports stall, bubble and synchronous reset.
- Sits between fetch (D register) and execute (E register). Replaces the file-loaded register array with a reset-initialised, internally written one.

---
 rtl/decode_stage_param.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/decode_stage_param.sv
// rtl/decode_stage_param.sv - Y86-64 decode/writeback stage: register file, source decode, operand forwarding and D->E register
module decode_stage_param #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 4,
  parameter int NREG = 15,
  parameter int RSP_ID = 4,
  parameter int STAT_W = 2,
  parameter logic [STAT_W-1:0] STAT_BUB = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [STAT_W-1:0] D_stat,
  input  logic [3:0]        D_in_code,
  input  logic [3:0]        D_in_fun,
  input  logic [REG_AW-1:0] D_ra,
  input  logic [REG_AW-1:0] D_rb,
  input  logic [DATA_W-1:0] D_val_c,
  input  logic [DATA_W-1:0] D_val_p,
  input  logic [REG_AW-1:0] e_dst_e,
  input  logic [DATA_W-1:0] e_val_e,
  input  logic [REG_AW-1:0] M_dst_e,
  input  logic [DATA_W-1:0] M_val_e,
  input  logic [REG_AW-1:0] M_dst_m,
  input  logic [DATA_W-1:0] m_val_m,
  input  logic [REG_AW-1:0] W_dst_e,
  input  logic [DATA_W-1:0] W_val_e,
  input  logic [REG_AW-1:0] W_dst_m,
  input  logic [DATA_W-1:0] W_val_m,
  input  logic              E_stall,
  input  logic              E_bub,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [REG_AW-1:0] d_src_a,
  output logic [REG_AW-1:0] d_src_b,
  output logic [DATA_W-1:0] d_val_a,
  output logic [DATA_W-1:0] d_val_b,
  output logic [STAT_W-1:0] E_stat,
  output logic [3:0]        E_in_code,
  output logic [3:0]        E_in_fun,
  output logic [DATA_W-1:0] E_val_c,
  output logic [DATA_W-1:0] E_val_a,
  output logic [DATA_W-1:0] E_val_b,
  output logic [REG_AW-1:0] E_dst_e,
  output logic [REG_AW-1:0] E_dst_m,
  output logic [REG_AW-1:0] E_src_a,
  output logic [REG_AW-1:0] E_src_b
);

  localparam logic [REG_AW-1:0] RNONE  = '1;
  localparam logic [REG_AW-1:0] RSP    = REG_AW'(RSP_ID);
  localparam logic [REG_AW:0]   NREG_W = (REG_AW+1)'(NREG);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [REG_AW-1:0] dst_e_d, dst_m_d;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic              we_e, we_m;

  logic [STAT_W-1:0] stat_q;
  logic [3:0]        code_q, fun_q;
  logic [DATA_W-1:0] val_c_q, val_a_q, val_b_q;
  logic [REG_AW-1:0] dst_e_q, dst_m_q, src_a_q, src_b_q;

  assign we_e = ({1'b0, W_dst_e} < NREG_W);
  assign we_m = ({1'b0, W_dst_m} < NREG_W);

  // Port M is written after port E so that it wins when both target one register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (we_e) rf_q[W_dst_e] <= W_val_e;
      if (we_m) rf_q[W_dst_m] <= W_val_m;
    end
  end

  assign rf_a     = ({1'b0, d_src_a}  < NREG_W) ? rf_q[d_src_a]  : '0;
  assign rf_b     = ({1'b0, d_src_b}  < NREG_W) ? rf_q[d_src_b]  : '0;
  assign dbg_data = ({1'b0, dbg_addr} < NREG_W) ? rf_q[dbg_addr] : '0;

  always_comb begin
    d_src_a = RNONE;
    d_src_b = RNONE;
    dst_e_d = RNONE;
    dst_m_d = RNONE;
    case (D_in_code)
      4'h2: begin d_src_a = D_ra; dst_e_d = D_rb; end
      4'h3: begin dst_e_d = D_rb; end
      4'h4: begin d_src_a = D_ra; d_src_b = D_rb; end
      4'h5: begin d_src_b = D_rb; dst_m_d = D_ra; end
      4'h6: begin d_src_a = D_ra; d_src_b = D_rb; dst_e_d = D_rb; end
      4'h8: begin d_src_b = RSP; dst_e_d = RSP; end
      4'h9: begin d_src_a = RSP; d_src_b = RSP; dst_e_d = RSP; end
      4'hA: begin d_src_a = D_ra; d_src_b = RSP; dst_e_d = RSP; end
      4'hB: begin d_src_a = RSP; d_src_b = RSP; dst_e_d = RSP; dst_m_d = D_ra; end
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] src,
                                            input logic [DATA_W-1:0] rf_val);
    if (src == RNONE)        return rf_val;
    else if (src == e_dst_e) return e_val_e;
    else if (src == M_dst_m) return m_val_m;
    else if (src == M_dst_e) return M_val_e;
    else if (src == W_dst_m) return W_val_m;
    else if (src == W_dst_e) return W_val_e;
    else                     return rf_val;
  endfunction

  // jXX and call carry valP down the pipe in valA instead of a register operand.
  always_comb begin
    d_val_a = fwd(d_src_a, rf_a);
    if (D_in_code == 4'h7 || D_in_code == 4'h8) d_val_a = D_val_p;
    d_val_b = fwd(d_src_b, rf_b);
  end

  always_ff @(posedge clock) begin
    if (reset || E_bub) begin
      stat_q  <= STAT_BUB;
      code_q  <= 4'h1;
      fun_q   <= 4'h0;
      val_c_q <= '0;
      val_a_q <= '0;
      val_b_q <= '0;
      dst_e_q <= RNONE;
      dst_m_q <= RNONE;
      src_a_q <= RNONE;
      src_b_q <= RNONE;
    end else if (!E_stall) begin
      stat_q  <= D_stat;
      code_q  <= D_in_code;
      fun_q   <= D_in_fun;
      val_c_q <= D_val_c;
      val_a_q <= d_val_a;
      val_b_q <= d_val_b;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
      src_a_q <= d_src_a;
      src_b_q <= d_src_b;
    end
  end

  assign E_stat    = stat_q;
  assign E_in_code = code_q;
  assign E_in_fun  = fun_q;
  assign E_val_c   = val_c_q;
  assign E_val_a   = val_a_q;
  assign E_val_b   = val_b_q;
  assign E_dst_e   = dst_e_q;
  assign E_dst_m   = dst_m_q;
  assign E_src_a   = src_a_q;
  assign E_src_b   = src_b_q;

endmodule
